// File: rtl/axi_to_reg_burst.sv
// AXI4 subordinate to Regbus initiator bridge: every burst beat becomes one
// single-beat Regbus access, with one AXI transaction in flight at a time.

package axi_to_reg_burst_pkg;
   localparam int unsigned DefAddrWidth = 32;
   localparam int unsigned DefDataWidth = 32;
   localparam int unsigned DefIdWidth   = 4;

   typedef logic [1:0] resp_t;
   typedef logic [1:0] burst_t;

   localparam resp_t  RespOkay   = 2'b00;
   localparam resp_t  RespSlvErr = 2'b10;
   localparam burst_t BurstFixed = 2'b00;
   localparam burst_t BurstWrap  = 2'b10;

   typedef struct packed {
      logic [DefIdWidth-1:0]   id;
      logic [DefAddrWidth-1:0] addr;
      logic [7:0]              len;
      logic [2:0]              size;
      burst_t                  burst;
      logic                    lock;
      logic [3:0]              cache;
      logic [2:0]              prot;
      logic [3:0]              qos;
      logic [3:0]              region;
      logic [5:0]              atop;
      logic                    user;
   } aw_chan_t;

   typedef struct packed {
      logic [DefIdWidth-1:0]   id;
      logic [DefAddrWidth-1:0] addr;
      logic [7:0]              len;
      logic [2:0]              size;
      burst_t                  burst;
      logic                    lock;
      logic [3:0]              cache;
      logic [2:0]              prot;
      logic [3:0]              qos;
      logic [3:0]              region;
      logic                    user;
   } ar_chan_t;

   typedef struct packed {
      logic [DefDataWidth-1:0]   data;
      logic [DefDataWidth/8-1:0] strb;
      logic                      last;
      logic                      user;
   } w_chan_t;

   typedef struct packed {
      logic [DefIdWidth-1:0] id;
      resp_t                 resp;
      logic                  user;
   } b_chan_t;

   typedef struct packed {
      logic [DefIdWidth-1:0]   id;
      logic [DefDataWidth-1:0] data;
      resp_t                   resp;
      logic                    last;
      logic                    user;
   } r_chan_t;

   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } axi_req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    r_valid;
      r_chan_t r;
   } axi_rsp_t;

   typedef struct packed {
      logic [DefAddrWidth-1:0]   addr;
      logic                      write;
      logic [DefDataWidth-1:0]   wdata;
      logic [DefDataWidth/8-1:0] wstrb;
      logic                      valid;
   } reg_req_t;

   typedef struct packed {
      logic [DefDataWidth-1:0] rdata;
      logic                    error;
      logic                    ready;
   } reg_rsp_t;
endpackage

module axi_to_reg_burst #(
   parameter int unsigned DataWidth = axi_to_reg_burst_pkg::DefDataWidth,
   parameter int unsigned AddrWidth = axi_to_reg_burst_pkg::DefAddrWidth,
   parameter int unsigned IdWidth   = axi_to_reg_burst_pkg::DefIdWidth,
   parameter type axi_req_t = axi_to_reg_burst_pkg::axi_req_t,
   parameter type axi_rsp_t = axi_to_reg_burst_pkg::axi_rsp_t,
   parameter type reg_req_t = axi_to_reg_burst_pkg::reg_req_t,
   parameter type reg_rsp_t = axi_to_reg_burst_pkg::reg_rsp_t
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   input  axi_req_t axi_req_i,
   output axi_rsp_t axi_rsp_o,
   output reg_req_t reg_req_o,
   input  reg_rsp_t reg_rsp_i
);
   import axi_to_reg_burst_pkg::RespOkay;
   import axi_to_reg_burst_pkg::RespSlvErr;
   import axi_to_reg_burst_pkg::BurstFixed;
   import axi_to_reg_burst_pkg::BurstWrap;

   localparam logic [2:0] MaxSize = 3'($clog2(DataWidth / 8));

   typedef enum logic [2:0] {IDLE, RD_REG, RD_RSP, WR_DATA, WR_RSP} state_e;

   state_e               state_q, state_d;
   logic [IdWidth-1:0]   id_q;
   logic [AddrWidth-1:0] addr_q, addr_next, step, wrap_mask;
   logic [7:0]           len_q, cnt_q;
   logic [2:0]           size_q;
   logic [1:0]           burst_q;
   logic                 size_err_q, err_q, rerr_q, last_wr_q;
   logic [DataWidth-1:0] rdata_q;
   logic                 aw_grant, ar_grant, beat_adv, rd_capture, wr_beat, is_last;
   logic                 unused;

   // Sideband fields (lock, cache, prot, qos, region, atop, user, w.last) are ignored.
   assign unused  = ^{axi_req_i, reg_rsp_i};
   assign is_last = (cnt_q == len_q);

   assign step      = AddrWidth'(1) << size_q;
   assign wrap_mask = ((AddrWidth'(len_q) + AddrWidth'(1)) << size_q) - AddrWidth'(1);

   always_comb begin
      case (burst_q)
         BurstFixed: addr_next = addr_q;
         BurstWrap:  addr_next = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
         default:    addr_next = addr_q + step;
      endcase
   end

   // NOTE: every output and strobe gets a default before the case, so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      axi_rsp_o  = '0;
      reg_req_o  = '0;
      aw_grant   = 1'b0;
      ar_grant   = 1'b0;
      beat_adv   = 1'b0;
      rd_capture = 1'b0;
      wr_beat    = 1'b0;
      case (state_q)
         IDLE: begin
            // On a conflict, the channel not granted last time wins.
            aw_grant = axi_req_i.aw_valid && (!axi_req_i.ar_valid || !last_wr_q);
            ar_grant = axi_req_i.ar_valid && !aw_grant;
            axi_rsp_o.aw_ready = aw_grant;
            axi_rsp_o.ar_ready = ar_grant;
            if (aw_grant)      state_d = WR_DATA;
            else if (ar_grant) state_d = RD_REG;
         end
         RD_REG: begin
            if (size_err_q) begin
               rd_capture = 1'b1;
               state_d    = RD_RSP;
            end else begin
               reg_req_o.valid = 1'b1;
               reg_req_o.addr  = addr_q;
               if (reg_rsp_i.ready) begin
                  rd_capture = 1'b1;
                  state_d    = RD_RSP;
               end
            end
         end
         RD_RSP: begin
            axi_rsp_o.r_valid = 1'b1;
            axi_rsp_o.r.data  = rdata_q;
            axi_rsp_o.r.resp  = rerr_q ? RespSlvErr : RespOkay;
            axi_rsp_o.r.id    = id_q;
            axi_rsp_o.r.last  = is_last;
            if (axi_req_i.r_ready) begin
               if (is_last) begin
                  state_d = IDLE;
               end else begin
                  beat_adv = 1'b1;
                  state_d  = RD_REG;
               end
            end
         end
         WR_DATA: begin
            if (size_err_q) begin
               axi_rsp_o.w_ready = 1'b1;
               wr_beat           = axi_req_i.w_valid;
            end else begin
               reg_req_o.valid   = axi_req_i.w_valid;
               reg_req_o.write   = 1'b1;
               reg_req_o.addr    = addr_q;
               reg_req_o.wdata   = axi_req_i.w.data;
               reg_req_o.wstrb   = axi_req_i.w.strb;
               axi_rsp_o.w_ready = reg_rsp_i.ready;
               wr_beat           = axi_req_i.w_valid && reg_rsp_i.ready;
            end
            if (wr_beat) begin
               if (is_last) state_d  = WR_RSP;
               else         beat_adv = 1'b1;
            end
         end
         WR_RSP: begin
            axi_rsp_o.b_valid = 1'b1;
            axi_rsp_o.b.id    = id_q;
            axi_rsp_o.b.resp  = err_q ? RespSlvErr : RespOkay;
            if (axi_req_i.b_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         id_q       <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         size_q     <= '0;
         burst_q    <= '0;
         cnt_q      <= '0;
         size_err_q <= 1'b0;
         err_q      <= 1'b0;
         rerr_q     <= 1'b0;
         rdata_q    <= '0;
         last_wr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         if (aw_grant) begin
            id_q       <= axi_req_i.aw.id;
            addr_q     <= AddrWidth'(axi_req_i.aw.addr);
            len_q      <= axi_req_i.aw.len;
            size_q     <= axi_req_i.aw.size;
            burst_q    <= axi_req_i.aw.burst;
            size_err_q <= axi_req_i.aw.size > MaxSize;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            last_wr_q  <= 1'b1;
         end else if (ar_grant) begin
            id_q       <= axi_req_i.ar.id;
            addr_q     <= AddrWidth'(axi_req_i.ar.addr);
            len_q      <= axi_req_i.ar.len;
            size_q     <= axi_req_i.ar.size;
            burst_q    <= axi_req_i.ar.burst;
            size_err_q <= axi_req_i.ar.size > MaxSize;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            last_wr_q  <= 1'b0;
         end
         if (beat_adv) begin
            cnt_q  <= cnt_q + 8'd1;
            addr_q <= addr_next;
         end
         if (rd_capture) begin
            rdata_q <= size_err_q ? '0 : reg_rsp_i.rdata;
            rerr_q  <= size_err_q | reg_rsp_i.error;
         end
         if (wr_beat) err_q <= err_q | size_err_q | reg_rsp_i.error;
      end
   end
endmodule

// File: tb/tb_axi_to_reg_burst.sv
// Scoreboard bench for axi_to_reg_burst: a Regbus responder model checks every
// access against expected queues; AXI responses are popped and compared on handshake.

module tb_axi_to_reg_burst;
   import axi_to_reg_burst_pkg::*;

   localparam logic [1:0] B_FIXED = 2'b00;
   localparam logic [1:0] B_INCR  = 2'b01;
   localparam logic [1:0] B_WRAP  = 2'b10;
   localparam logic [1:0] OKAY    = 2'b00;
   localparam logic [1:0] SLVERR  = 2'b10;

   logic     clk_i = 1'b0;
   logic     rst_ni;
   axi_req_t axi_req;
   axi_rsp_t axi_rsp;
   reg_req_t reg_req;
   reg_rsp_t reg_rsp;

   axi_to_reg_burst #(
      .DataWidth(32), .AddrWidth(32), .IdWidth(4),
      .axi_req_t(axi_req_t), .axi_rsp_t(axi_rsp_t),
      .reg_req_t(reg_req_t), .reg_rsp_t(reg_rsp_t)
   ) dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .axi_req_i(axi_req),
      .axi_rsp_o(axi_rsp),
      .reg_req_o(reg_req),
      .reg_rsp_i(reg_rsp)
   );

   always #5 clk_i = ~clk_i;

   typedef struct { logic [31:0] addr; logic write; logic [31:0] wdata; logic [3:0] wstrb; } reg_exp_t;
   typedef struct { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_exp_t;
   typedef struct { logic [3:0] id; logic [1:0] resp; } b_exp_t;
   typedef enum { CH_AW, CH_W, CH_AR, CH_B } ch_e;

   reg_exp_t exp_reg[$];
   r_exp_t   exp_r[$];
   b_exp_t   exp_b[$];

   int n_checks = 0;
   int n_errors = 0;
   int reg_lat  = 0;
   int err_idx  = -1;
   int acc_idx  = 0;
   int wait_cnt = 0;
   reg_exp_t e_reg;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] beat_addr(input logic [31:0] start, input int i, input int size,
                                             input int len, input logic [1:0] burst);
      logic [31:0] bytes, win, base;
      bytes = 32'd1 << size;
      win   = 32'(len + 1) * bytes;
      base  = start - (start % win);
      case (burst)
         B_FIXED: return start;
         B_WRAP:  return base + ((start - base + 32'(i) * bytes) % win);
         default: return start + 32'(i) * bytes;
      endcase
   endfunction

   // Regbus responder: ready after reg_lat waiting cycles, rdata = address.
   initial begin
      reg_rsp = '0;
      forever begin
         @(negedge clk_i);
         reg_rsp = '0;
         if (!rst_ni || !reg_req.valid) begin
            wait_cnt = 0;
         end else if (wait_cnt < reg_lat) begin
            wait_cnt++;
            #1;
            if (reg_req.write) check("w_ready_while_waiting", axi_rsp.w_ready, 1'b0);
         end else begin
            wait_cnt      = 0;
            reg_rsp.ready = 1'b1;
            reg_rsp.rdata = reg_req.addr;
            reg_rsp.error = (acc_idx == err_idx);
            acc_idx++;
            if (exp_reg.size() == 0) begin
               check("reg_unexpected_valid", reg_req.valid, 1'b0);
            end else begin
               e_reg = exp_reg.pop_front();
               check("reg_addr", reg_req.addr, e_reg.addr);
               check("reg_write", reg_req.write, e_reg.write);
               check("reg_wdata", reg_req.wdata, e_reg.wdata);
               check("reg_wstrb", reg_req.wstrb, e_reg.wstrb);
            end
            #1;
            if (reg_req.write) check("w_ready_on_reg_ready", axi_rsp.w_ready, 1'b1);
         end
      end
   end

   function automatic logic hs_now(input ch_e ch);
      case (ch)
         CH_AW:   return axi_req.aw_valid && axi_rsp.aw_ready;
         CH_W:    return axi_req.w_valid && axi_rsp.w_ready;
         CH_AR:   return axi_req.ar_valid && axi_rsp.ar_ready;
         default: return axi_rsp.b_valid && axi_req.b_ready;
      endcase
   endfunction

   // Samples between edges; returns just after the handshake edge.
   task automatic wait_hs(input ch_e ch, input string tag, output axi_rsp_t snap);
      int   cyc = 0;
      logic hs  = 1'b0;
      snap = '0;
      while (!hs && cyc < 200) begin
         @(negedge clk_i);
         #2;
         hs = hs_now(ch);
         if (hs) snap = axi_rsp;
         cyc++;
      end
      if (!hs) check({"handshake_", tag}, hs, 1'b1);
      @(posedge clk_i);
      #1;
   endtask

   task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input logic [1:0] burst);
      axi_rsp_t s;
      axi_req.aw       = '0;
      axi_req.aw.id    = id;
      axi_req.aw.addr  = addr;
      axi_req.aw.len   = 8'(len);
      axi_req.aw.size  = 3'(size);
      axi_req.aw.burst = burst;
      axi_req.aw_valid = 1'b1;
      wait_hs(CH_AW, "aw", s);
      axi_req.aw_valid = 1'b0;
   endtask

   task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input logic [1:0] burst);
      axi_rsp_t s;
      axi_req.ar       = '0;
      axi_req.ar.id    = id;
      axi_req.ar.addr  = addr;
      axi_req.ar.len   = 8'(len);
      axi_req.ar.size  = 3'(size);
      axi_req.ar.burst = burst;
      axi_req.ar_valid = 1'b1;
      wait_hs(CH_AR, "ar", s);
      axi_req.ar_valid = 1'b0;
   endtask

   task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input logic last);
      axi_rsp_t s;
      axi_req.w.data  = data;
      axi_req.w.strb  = strb;
      axi_req.w.last  = last;
      axi_req.w_valid = 1'b1;
      wait_hs(CH_W, "w", s);
      axi_req.w_valid = 1'b0;
   endtask

   task automatic recv_b(input string tag);
      axi_rsp_t s;
      b_exp_t   e;
      axi_req.b_ready = 1'b1;
      wait_hs(CH_B, tag, s);
      axi_req.b_ready = 1'b0;
      e = exp_b.pop_front();
      check({tag, "_bid"}, s.b.id, e.id);
      check({tag, "_bresp"}, s.b.resp, e.resp);
   endtask

   task automatic recv_r(input int n, input string tag);
      r_exp_t e;
      int left = n;
      int cyc  = 0;
      while (left > 0 && cyc < 400) begin
         axi_req.r_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk_i);
         #2;
         if (axi_rsp.r_valid && axi_req.r_ready) begin
            e = exp_r.pop_front();
            check({tag, "_rdata"}, axi_rsp.r.data, e.data);
            check({tag, "_rresp"}, axi_rsp.r.resp, e.resp);
            check({tag, "_rlast"}, axi_rsp.r.last, e.last);
            check({tag, "_rid"}, axi_rsp.r.id, e.id);
            left--;
         end
         @(posedge clk_i);
         #1;
         cyc++;
      end
      axi_req.r_ready = 1'b0;
      if (left != 0) check({tag, "_beats_left"}, left, 0);
   endtask

   task automatic push_reg(input logic [31:0] addr, input logic write, input logic [31:0] wdata,
                           input logic [3:0] wstrb);
      reg_exp_t e;
      e.addr = addr; e.write = write; e.wdata = wdata; e.wstrb = wstrb;
      exp_reg.push_back(e);
   endtask

   task automatic do_write(input string tag, input logic [3:0] id, input logic [31:0] addr,
                           input int len, input int size, input logic [1:0] burst,
                           input logic [31:0] seed, input int lat, input int eidx,
                           input logic [1:0] bresp);
      b_exp_t b;
      for (int i = 0; i <= len; i++)
         if ((1 << size) <= 4) push_reg(beat_addr(addr, i, size, len, burst), 1'b1, seed + 32'(i), 4'hF);
      b.id = id; b.resp = bresp;
      exp_b.push_back(b);
      reg_lat = lat; err_idx = eidx; acc_idx = 0;
      send_aw(id, addr, len, size, burst);
      for (int i = 0; i <= len; i++) send_w(seed + 32'(i), 4'hF, i == len);
      recv_b(tag);
   endtask

   task automatic do_read(input string tag, input logic [3:0] id, input logic [31:0] addr,
                          input int len, input int size, input logic [1:0] burst,
                          input int lat, input int eidx);
      r_exp_t r;
      logic   bad;
      bad = (1 << size) > 4;
      for (int i = 0; i <= len; i++) begin
         if (!bad) push_reg(beat_addr(addr, i, size, len, burst), 1'b0, 32'h0, 4'h0);
         r.id   = id;
         r.data = bad ? 32'h0 : beat_addr(addr, i, size, len, burst);
         r.resp = (bad || i == eidx) ? SLVERR : OKAY;
         r.last = (i == len);
         exp_r.push_back(r);
      end
      reg_lat = lat; err_idx = eidx; acc_idx = 0;
      send_ar(id, addr, len, size, burst);
      recv_r(len + 1, tag);
   endtask

   // Two back-to-back AW/AR conflicts: write wins first, the pending read wins next.
   task automatic arb_test();
      axi_rsp_t s;
      b_exp_t   b;
      r_exp_t   r;
      push_reg(32'h600, 1'b1, 32'h6, 4'hF);
      push_reg(32'h700, 1'b0, 32'h0, 4'h0);
      push_reg(32'h800, 1'b1, 32'h8, 4'hF);
      b.id = 4'd1; b.resp = OKAY; exp_b.push_back(b);
      b.id = 4'd3; b.resp = OKAY; exp_b.push_back(b);
      r.id = 4'd2; r.data = 32'h700; r.resp = OKAY; r.last = 1'b1; exp_r.push_back(r);
      reg_lat = 0; err_idx = -1; acc_idx = 0;
      axi_req.aw = '0; axi_req.aw.id = 4'd1; axi_req.aw.addr = 32'h600;
      axi_req.aw.size = 3'd2; axi_req.aw.burst = B_INCR;
      axi_req.ar = '0; axi_req.ar.id = 4'd2; axi_req.ar.addr = 32'h700;
      axi_req.ar.size = 3'd2; axi_req.ar.burst = B_INCR;
      axi_req.aw_valid = 1'b1;
      axi_req.ar_valid = 1'b1;
      @(negedge clk_i);
      #2;
      check("arb1_aw_ready", axi_rsp.aw_ready, 1'b1);
      check("arb1_ar_ready", axi_rsp.ar_ready, 1'b0);
      @(posedge clk_i);
      #1;
      axi_req.aw.id   = 4'd3;
      axi_req.aw.addr = 32'h800;
      send_w(32'h6, 4'hF, 1'b1);
      recv_b("arb_w1");
      @(negedge clk_i);
      #2;
      check("arb2_ar_ready", axi_rsp.ar_ready, 1'b1);
      check("arb2_aw_ready", axi_rsp.aw_ready, 1'b0);
      @(posedge clk_i);
      #1;
      axi_req.ar_valid = 1'b0;
      recv_r(1, "arb_r1");
      wait_hs(CH_AW, "arb_aw2", s);
      axi_req.aw_valid = 1'b0;
      send_w(32'h8, 4'hF, 1'b1);
      recv_b("arb_w2");
   endtask

   task automatic reset_test();
      int cyc = 0;
      push_reg(32'h900, 1'b0, 32'h0, 4'h0);
      reg_lat = 0; err_idx = -1; acc_idx = 0;
      send_ar(4'd8, 32'h900, 3, 2, B_INCR);
      while (!axi_rsp.r_valid && cyc < 50) begin
         @(negedge clk_i);
         #2;
         cyc++;
      end
      check("rst_rvalid_seen", axi_rsp.r_valid, 1'b1);
      rst_ni = 1'b0;
      #1;
      check("rst_async_rvalid", axi_rsp.r_valid, 1'b0);
      check("rst_async_regvalid", reg_req.valid, 1'b0);
      check("rst_async_bvalid", axi_rsp.b_valid, 1'b0);
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      axi_req.r_ready = 1'b1;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      #2;
      check("post_rst_rvalid", axi_rsp.r_valid, 1'b0);
      check("post_rst_regvalid", reg_req.valid, 1'b0);
      @(posedge clk_i);
      #1;
      axi_req.r_ready = 1'b0;
      do_read("rd_after_rst", 4'd10, 32'h180, 1, 2, B_INCR, 1, -1);
   endtask

   initial begin
      axi_req = '0;
      rst_ni  = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      #2;
      check("rst_aw_ready", axi_rsp.aw_ready, 1'b0);
      check("rst_ar_ready", axi_rsp.ar_ready, 1'b0);
      check("rst_w_ready", axi_rsp.w_ready, 1'b0);
      check("rst_r_valid", axi_rsp.r_valid, 1'b0);
      check("rst_b_valid", axi_rsp.b_valid, 1'b0);
      check("rst_reg_valid", reg_req.valid, 1'b0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      @(posedge clk_i);
      #1;

      arb_test();
      do_write("wr_single", 4'd5, 32'h10, 0, 2, B_INCR, 32'hDEADBEEF, 2, -1, OKAY);
      do_read("rd_incr", 4'd3, 32'h100, 3, 2, B_INCR, 1, -1);
      do_read("rd_wrap", 4'd2, 32'h38, 3, 2, B_WRAP, 0, -1);
      do_write("wr_fixed", 4'd1, 32'h20, 1, 2, B_FIXED, 32'h1111_0000, 0, -1, OKAY);
      do_write("wr_err", 4'd7, 32'h200, 3, 2, B_INCR, 32'hA000_0000, 1, 2, SLVERR);
      do_read("rd_err", 4'd6, 32'h300, 3, 2, B_INCR, 0, 1);
      do_read("rd_size", 4'd4, 32'h400, 1, 3, B_INCR, 0, -1);
      do_write("wr_size", 4'd9, 32'h500, 1, 3, B_INCR, 32'h5000_0000, 0, -1, SLVERR);
      reset_test();

      repeat (3) @(posedge clk_i);
      check("reg_queue_left", exp_reg.size(), 0);
      check("r_queue_left", exp_r.size(), 0);
      check("b_queue_left", exp_b.size(), 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
